// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler: scans the attribute table after each hblank and
// loads up to SLOTS visible sprites into the engine's line slots for the next line.
module sprite_line_scheduler #(
  parameter int unsigned MAX_SPRITES = 8,
  parameter int unsigned SLOTS       = 4,
  parameter int unsigned IDXW        = 3,
  localparam int unsigned SW = (SLOTS > 1) ? $clog2(SLOTS) : 1,
  localparam int unsigned CW = $clog2(SLOTS) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            hblank_start,
  input  logic            frame_start,
  input  logic [9:0]      next_y,
  input  logic            cpu_attr_busy,
  output logic            attr_rd_en,
  output logic [IDXW-1:0] attr_rd_idx,
  input  logic            attr_en,
  input  logic [9:0]      attr_y,
  input  logic [4:0]      attr_h,
  output logic            slot_clear,
  output logic            slot_load,
  output logic [SW-1:0]   slot_idx,
  output logic [IDXW-1:0] slot_sprite,
  output logic [4:0]      slot_row,
  output logic [CW-1:0]   slot_count,
  output logic            busy,
  output logic            line_done,
  output logic            overflow_flag,
  output logic            late_flag,
  output logic            irq
);

  typedef enum logic [1:0] {IDLE, ISSUE, CHECK, DONE} state_t;

  state_t          state_q, state_d;
  logic [9:0]      y_q, y_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [CW-1:0]   count_q, count_d;
  logic            clear_q, clear_d;
  logic            ovf_q, late_q;
  logic            ovf_set, late_set;
  logic            start;
  logic [10:0]     diff;
  logic            hit;

  // Signed row distance; a negative result (bit 10) means the sprite starts below this line.
  assign diff = {1'b0, y_q} - {1'b0, attr_y};
  assign hit  = attr_en && !diff[10] && (diff[9:0] < 10'(attr_h));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      y_q     <= '0;
      idx_q   <= '0;
      count_q <= '0;
      clear_q <= 1'b0;
      ovf_q   <= 1'b0;
      late_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      clear_q <= clear_d;
      ovf_q   <= ovf_set  | (ovf_q  & ~frame_start);
      late_q  <= late_set | (late_q & ~frame_start);
    end
  end

  always_comb begin
    state_d     = state_q;
    y_d         = y_q;
    idx_d       = idx_q;
    count_d     = count_q;
    clear_d     = 1'b0;
    ovf_set     = 1'b0;
    late_set    = 1'b0;
    start       = 1'b0;
    attr_rd_en  = 1'b0;
    attr_rd_idx = '0;
    slot_load   = 1'b0;
    slot_idx    = '0;
    slot_sprite = '0;
    slot_row    = '0;
    line_done   = 1'b0;

    unique case (state_q)
      IDLE: start = hblank_start;
      ISSUE: begin
        if (hblank_start) begin
          late_set = 1'b1;
          start    = 1'b1;
        end else if (!cpu_attr_busy) begin
          attr_rd_en  = 1'b1;
          attr_rd_idx = idx_q;
          state_d     = CHECK;
        end
      end
      CHECK: begin
        if (hblank_start) begin
          late_set = 1'b1;
          start    = 1'b1;
        end else if (hit && (count_q == CW'(SLOTS))) begin
          ovf_set = 1'b1;
          state_d = DONE;
        end else begin
          if (hit) begin
            slot_load   = 1'b1;
            slot_idx    = SW'(count_q);
            slot_sprite = idx_q;
            slot_row    = diff[4:0];
            count_d     = count_q + CW'(1);
          end
          if (idx_q == IDXW'(MAX_SPRITES - 1)) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IDXW'(1);
            state_d = ISSUE;
          end
        end
      end
      DONE: begin
        line_done = 1'b1;
        state_d   = IDLE;
        start     = hblank_start;
      end
      default: state_d = IDLE;
    endcase

    // A new hblank always restarts the scan from entry 0 with empty slots.
    if (start) begin
      y_d     = next_y;
      idx_d   = '0;
      count_d = '0;
      clear_d = 1'b1;
      state_d = ISSUE;
    end

    // Reset suppresses the strobes of the cycle it arrives in, so no half-loaded line escapes.
    if (reset) begin
      attr_rd_en  = 1'b0;
      attr_rd_idx = '0;
      slot_load   = 1'b0;
      slot_idx    = '0;
      slot_sprite = '0;
      slot_row    = '0;
      line_done   = 1'b0;
    end
  end

  assign slot_clear    = clear_q;
  assign slot_count    = count_q;
  assign busy          = (state_q != IDLE);
  assign overflow_flag = ovf_q;
  assign late_flag     = late_q;
  assign irq           = ovf_q | late_q;

endmodule
